dbus_mem: RTL

Word-organised scratchpad RAM that acts as a DBus responder: it answers the load/store requests the core's load/store unit issues, inserting a programmable number of wait states and flagging illegal accesses with `dbus_err`. It sits on the data bus next to other responders. It drives `dbus_wait`, `dbus_err` and `dbus_rd_data` only when its own address window is selected, so an interconnect can OR the responses of all responders together.

---
 rtl/dbus_mem.sv | 110 +++++++++++
 1 files changed

// File: rtl/dbus_mem.sv
// Word-organised scratchpad RAM answering DBus loads/stores with programmable wait states.
// Outputs are zero unless the address window is selected, so responders can be OR-ed together.

module dbus_mem_lane #(
    parameter int WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] idx,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdq
);
    logic [7:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Read register samples the live index every cycle; only the completion cycle exposes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdq <= '0;
        else     rdq <= mem[idx];
    end
endmodule

module dbus_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h2000_0000,
    parameter int          SIZE_BYTES  = 4096,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbus_rd_en,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wr_data,
    input  logic [3:0]  dbus_wr_strobe,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_wait,
    output logic        dbus_err
);
    localparam int          AW       = $clog2(SIZE_BYTES);
    localparam int          WORDS    = SIZE_BYTES / 4;
    localparam logic [31:0] WIN_MASK = ~(32'(SIZE_BYTES) - 32'd1);
    localparam logic [2:0]  N        = 3'(WAIT_STATES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic            req, sel, bad, go, done;
    logic [1:0]      off;
    logic [AW-3:0]   idx;
    logic [7:0]      lanes;
    logic [3:0][7:0] wdata_sh;
    logic [3:0][7:0] rdq;

    assign req      = dbus_rd_en | dbus_wr_en;
    assign sel      = (dbus_addr & WIN_MASK) == ADDR_BASE;
    assign off      = dbus_addr[1:0];
    assign idx      = dbus_addr[AW-1:2];
    assign lanes    = {4'b0000, dbus_wr_strobe} << off;
    assign wdata_sh = dbus_wr_data << {off, 3'b000};

    // Any lane pushed past byte 3 is a misaligned half/word store.
    assign bad  = (dbus_rd_en & dbus_wr_en) | (dbus_wr_en & (|lanes[7:4]));
    assign go   = req & sel & ~bad;
    assign done = (state == BUSY) & go & (cnt == N);

    assign dbus_wait    = go & (cnt != N);
    assign dbus_err     = req & sel & bad;
    assign dbus_rd_data = (done & dbus_rd_en) ? (rdq >> {off, 3'b000}) : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state <= BUSY;
                    cnt   <= 3'd1;
                end
                BUSY: if (!go || cnt == N) begin
                    // Completion or initiator abort; either way the next cycle is IDLE.
                    state <= IDLE;
                    cnt   <= 3'd0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        dbus_mem_lane #(.WORDS(WORDS)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (done & dbus_wr_en & lanes[i]),
            .idx   (idx),
            .wdata (wdata_sh[i]),
            .rdq   (rdq[i])
        );
    end
endmodule
